// File: rtl/bscan_arbiter_pkg.sv
// bscan_arbiter_pkg: shared Bscan word geometry for the arbiter and its endpoint blocks
package bscan_arbiter_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int TAGW_DEF  = 2;
    localparam int TAG_MSB   = WIDTH_DEF - 1;
    localparam int TAG_LSB   = WIDTH_DEF - TAGW_DEF;
    localparam int PAY_MSB   = TAG_LSB - 1;
    localparam int PAY_LSB   = 0;
endpackage

// File: rtl/bscan_arbiter_rr_pick.sv
// rr_pick: round-robin picker, first requester after last grant wins
module rr_pick #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  idx,
    output logic           any
);
    logic [IW-1:0] c;
    // scan farthest-to-nearest so the nearest requester after last overwrites
    always_comb begin
        grant = '0;
        idx   = last;
        any   = |req;
        c     = last;
        for (int k = NCH; k >= 1; k--) begin
            c = last + IW'(k);
            if (req[c]) begin
                idx   = c;
                grant = NCH'(1) << c;
            end
        end
    end
endmodule

// File: rtl/bscan_arbiter.sv
// bscan_arbiter: multiplexes NCH tagged channels onto one Bscan word link and demuxes replies
module bscan_arbiter
    import bscan_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAGW  = TAGW_DEF,
    parameter int NCH   = 2**TAGW
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [NCH-1:0]              txValid,
    input  logic [NCH*(WIDTH-TAGW)-1:0] txData,
    output logic [NCH-1:0]              txAck,
    output logic                        toBscan__ENA,
    output logic [WIDTH-1:0]            toBscan_v,
    input  logic                        toBscan__RDY,
    input  logic                        fromBscan__ENA,
    input  logic [WIDTH-1:0]            fromBscan_v,
    output logic                        fromBscan__RDY,
    output logic [NCH-1:0]              rxValid,
    output logic [WIDTH-TAGW-1:0]       rxData,
    input  logic [NCH-1:0]              rxReady,
    output logic [NCH*8-1:0]            txCount
);
    localparam int PW = WIDTH - TAGW;

    logic            hValid, rValid;
    logic [TAGW-1:0] hTag, rTag, lastGrant, gIdx;
    logic [PW-1:0]   hData, rData;
    logic [NCH-1:0]  grant;
    logic            gAny, drain, load, rxLoad;
    logic [7:0]      cnt [NCH];

    rr_pick #(.NCH(NCH), .IW(TAGW)) uPick (
        .req  (txValid),
        .last (lastGrant),
        .grant(grant),
        .idx  (gIdx),
        .any  (gAny)
    );

    // handshake decode; grants are masked in reset so no ack escapes
    always_comb begin
        drain          = hValid && toBscan__RDY;
        load           = nRST && gAny && (!hValid || drain);
        txAck          = load ? grant : '0;
        toBscan__ENA   = hValid;
        toBscan_v      = {hTag, hData};
        fromBscan__RDY = !rValid || rxReady[rTag];
        rxLoad         = fromBscan__ENA && fromBscan__RDY;
        rxValid        = NCH'(rValid) << rTag;
        rxData         = rData;
    end

    // TX holding register, round-robin pointer and delivery counters
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hValid    <= 1'b0;
            hTag      <= '0;
            hData     <= '0;
            lastGrant <= TAGW'(NCH - 1);
            for (int k = 0; k < NCH; k++) cnt[k] <= 8'd0;
        end else begin
            if (load) begin
                hValid    <= 1'b1;
                hTag      <= gIdx;
                hData     <= txData[gIdx*PW +: PW];
                lastGrant <= gIdx;
            end else if (drain) begin
                hValid <= 1'b0;
            end
            if (drain) cnt[hTag] <= cnt[hTag] + 8'd1;
        end
    end

    // RX one-entry buffer; a load in the drain cycle keeps it full with the new word
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rValid <= 1'b0;
            rTag   <= '0;
            rData  <= '0;
        end else if (rxLoad) begin
            rValid <= 1'b1;
            rTag   <= fromBscan_v[WIDTH-1 -: TAGW];
            rData  <= fromBscan_v[PW-1:0];
        end else if (rValid && rxReady[rTag]) begin
            rValid <= 1'b0;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : gCnt
            assign txCount[i*8 +: 8] = cnt[i];
        end
    endgenerate
endmodule
